// File: rtl/fifo_reader_pkg.sv
// fifo_reader shared types: FSM states, skid depth, pointer helper.
// Optional rd_count port is enabled by FIFO_READER_CNT_EN.
package fifo_reader_pkg;

  localparam int BUF_DEPTH = 3;
  localparam logic [1:0] LAST_PTR = 2'(BUF_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  function automatic logic [1:0] ptr_inc(
    input logic [1:0] p
  );
    return (p == LAST_PTR) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/fifo_reader_skid.sv
// fifo_reader_skid: 3-entry circular skid buffer.
// Head word is always visible on data; clear empties it.
module fifo_reader_skid
  import fifo_reader_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [BUF_DEPTH];
  logic [1:0]       wr_ptr;
  logic [1:0]       rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      count <= count + {1'b0, push}
                     - {1'b0, pop};
    end
  end

  assign data = mem[rd_ptr];

endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: pops a FIFO into a valid/ready stream via a skid buffer.
// Define FIFO_READER_CNT_EN to add the 16-bit rd_count transfer counter.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             flush,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_rd_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             flush_busy
`ifdef FIFO_READER_CNT_EN
  ,
  output logic [15:0]      rd_count
`endif
);

  localparam int BUF_DEPTH = fifo_reader_pkg::BUF_DEPTH;

  state_t     state;
  state_t     state_nxt;
  logic       pending;
  logic [1:0] count;
  logic       push;
  logic       xfer;
  logic       clear;
  logic [2:0] occupancy;

  assign occupancy = {1'b0, count} + {2'b0, pending};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pending <= 1'b0;
    end else begin
      state   <= state_nxt;
      pending <= fifo_rd_en;
    end
  end

  always_comb begin
    state_nxt  = state;
    fifo_rd_en = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        // room must cover the word already in flight
        fifo_rd_en = !fifo_empty &&
                     (occupancy < 3'(BUF_DEPTH));
        if (!enable) state_nxt = IDLE;
      end
      FLUSH: begin
        fifo_rd_en = !fifo_empty;
        if (fifo_empty && !pending)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = FLUSH;
  end

  assign flush_busy = (state == FLUSH);
  assign push       = pending && !flush_busy;
  assign clear      = (state_nxt == FLUSH);
  assign m_valid    = (count != 2'd0) && !flush_busy;
  assign xfer       = m_valid && m_ready;

  fifo_reader_skid #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (push),
    .wdata (fifo_rd_data),
    .pop   (xfer),
    .data  (m_data),
    .count (count)
  );

`ifdef FIFO_READER_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count <= '0;
    end else if (xfer) begin
      rd_count <= rd_count + 16'd1;
    end
  end
`endif

endmodule
